// File: rtl/slc3_pkg.sv
// Types and default timing shared by the SLC-3 memory-side blocks.
package slc3_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ACT,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } mem_state_t;

  localparam int SRAM_RD_WAIT = 2;
  localparam int SRAM_WR_WAIT = 2;

  typedef logic [3:0] wait_cnt_t;

endpackage

// File: rtl/sram_ctrl.sv
// Word-at-a-time sequencer for the board's asynchronous 16-bit SRAM.
//
// state    | meaning
// IDLE     | strobes inactive, waiting for req
// RD_ACT   | CE/OE asserted, read data captured when cnt reaches 0
// WR_SETUP | CE asserted, data driven, WE still high
// WR_PULSE | WE low for WR_WAIT cycles
// WR_HOLD  | WE released, data still driven
// DONE     | one-cycle ready pulse
module sram_ctrl
  import slc3_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int RD_WAIT = SRAM_RD_WAIT,
  parameter int WR_WAIT = SRAM_WR_WAIT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic [ADDR_W-1:0] A,
  output logic              CE_N,
  output logic              OE_N,
  output logic              WE_N,
  output logic              UB_N,
  output logic              LB_N,
  input  logic [DATA_W-1:0] dq_in,
  output logic [DATA_W-1:0] dq_out,
  output logic              dq_oe
);

  localparam wait_cnt_t RD_LOAD = wait_cnt_t'(RD_WAIT - 1);
  localparam wait_cnt_t WR_LOAD = wait_cnt_t'(WR_WAIT - 1);

  mem_state_t state_q, state_d;
  wait_cnt_t  cnt_q;
  logic [1:0] be_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (req) state_d = we ? WR_SETUP : RD_ACT;
      RD_ACT:   if (cnt_q == '0) state_d = DONE;
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: if (cnt_q == '0) state_d = WR_HOLD;
      WR_HOLD:  state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Address and write data are only loaded on accept, so the pins stay put mid-transaction.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      A      <= '0;
      dq_out <= '0;
      be_q   <= '0;
      rdata  <= '0;
      cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            A      <= addr;
            dq_out <= wdata;
            be_q   <= be;
            cnt_q  <= RD_LOAD;
          end
        end
        RD_ACT: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else             rdata <= dq_in;
        end
        WR_SETUP: cnt_q <= WR_LOAD;
        WR_PULSE: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Strobes decode from state and registered byte enables only.
  always_comb begin
    CE_N  = 1'b1;
    OE_N  = 1'b1;
    WE_N  = 1'b1;
    UB_N  = 1'b1;
    LB_N  = 1'b1;
    dq_oe = 1'b0;
    ready = 1'b0;
    busy  = (state_q != IDLE);
    case (state_q)
      RD_ACT: begin
        CE_N = 1'b0;
        OE_N = 1'b0;
        UB_N = 1'b0;
        LB_N = 1'b0;
      end
      WR_SETUP, WR_PULSE, WR_HOLD: begin
        CE_N  = 1'b0;
        WE_N  = (state_q != WR_PULSE);
        UB_N  = ~be_q[1];
        LB_N  = ~be_q[0];
        dq_oe = 1'b1;
      end
      DONE:    ready = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized and directed bench for sram_ctrl against a behavioural SRAM and reference memory.
module tb_sram_ctrl;

  localparam int RD_WAIT = 2;
  localparam int WR_WAIT = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  be = 2'b00;
  logic [19:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        ready, busy;
  logic [19:0] A;
  logic        CE_N, OE_N, WE_N, UB_N, LB_N;
  logic [15:0] dq_in, dq_out;
  logic        dq_oe;

  int checks = 0;
  int errors = 0;

  sram_ctrl #(.ADDR_W(20), .DATA_W(16), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .busy(busy), .A(A),
    .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N), .UB_N(UB_N), .LB_N(LB_N),
    .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe)
  );

  always #5 Clk = ~Clk;

  // Behavioural SRAM: 64 words, aliased on the low address bits.
  logic [15:0] sram [64];
  logic [15:0] exp_mem [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [15:0] pl_val = '0;

  assign dq_in = (!CE_N && !OE_N) ? sram[A[5:0]] : 16'h0000;

  always @(negedge Clk) begin
    if (pl_en) sram[pl_idx] <= pl_val;
    else if (!CE_N && !WE_N) begin
      if (!UB_N) sram[A[5:0]][15:8] <= dq_out[15:8];
      if (!LB_N) sram[A[5:0]][7:0]  <= dq_out[7:0];
    end
  end

  task automatic preload(input logic [5:0] idx, input logic [15:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge Clk); #1;
    pl_en = 1'b0;
    exp_mem[idx] = val;
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw, input logic [1:0] b);
    logic [15:0] r;
    r = old;
    if (b[1]) r[15:8] = nw[15:8];
    if (b[0]) r[7:0]  = nw[7:0];
    return r;
  endfunction

  int obs_ready_cyc, obs_ready_cnt, obs_oe_first, obs_oe_last, obs_oe_cnt, obs_ce_cnt;
  int obs_we_first, obs_we_cnt, obs_dqoe_first, obs_dqoe_cnt, obs_busy_cnt;
  int obs_overlap, obs_a_bad, obs_ublb_bad;

  // Issues one transaction from IDLE (called #1 after a rising edge) and records per-cycle behaviour.
  task automatic run_txn(input logic t_we, input logic [1:0] t_be, input logic [19:0] t_addr,
                         input logic [15:0] t_wdata);
    req = 1'b1; we = t_we; be = t_be; addr = t_addr; wdata = t_wdata;
    @(posedge Clk); #1;
    req = 1'b0; addr = 20'($urandom); wdata = 16'($urandom); we = 1'($urandom); be = 2'($urandom);
    obs_ready_cyc = 0; obs_ready_cnt = 0; obs_oe_first = 0; obs_oe_last = 0; obs_oe_cnt = 0;
    obs_ce_cnt = 0; obs_we_first = 0; obs_we_cnt = 0; obs_dqoe_first = 0; obs_dqoe_cnt = 0;
    obs_busy_cnt = 0; obs_overlap = 0; obs_a_bad = 0; obs_ublb_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clk);
      if (busy) obs_busy_cnt++;
      if (!CE_N) obs_ce_cnt++;
      if (!OE_N) begin
        if (obs_oe_first == 0) obs_oe_first = c;
        obs_oe_last = c; obs_oe_cnt++;
        if (UB_N !== 1'b0 || LB_N !== 1'b0) obs_ublb_bad++;
      end
      if (!WE_N) begin
        if (obs_we_first == 0) obs_we_first = c;
        obs_we_cnt++;
      end
      if (dq_oe) begin
        if (obs_dqoe_first == 0) obs_dqoe_first = c;
        obs_dqoe_cnt++;
        if (UB_N !== ~t_be[1] || LB_N !== ~t_be[0] || CE_N !== 1'b0) obs_ublb_bad++;
      end
      if ((!OE_N && !WE_N) || (!OE_N && dq_oe)) obs_overlap++;
      if (A !== t_addr) obs_a_bad++;
      if (ready) begin
        obs_ready_cnt++;
        if (obs_ready_cyc == 0) obs_ready_cyc = c;
      end
      if (obs_ready_cyc != 0 && c >= obs_ready_cyc + 2) break;
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset;
    req = 1'b1; we = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checks++; if (rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata got %h want 0000", rdata); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (A !== 20'h0) begin errors++; $display("FAIL reset_A got %h want 00000", A); end
    checks++; if (dq_out !== 16'h0 || dq_oe !== 1'b0) begin errors++; $display("FAIL reset_dq got %h/%b want 0000/0", dq_out, dq_oe); end
    checks++; if ({CE_N, OE_N, WE_N, UB_N, LB_N} !== 5'b11111) begin errors++; $display("FAIL reset_strobes got %b want 11111", {CE_N, OE_N, WE_N, UB_N, LB_N}); end
    req = 1'b0;
    Reset = 1'b0;
    @(posedge Clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_no_accept busy got %b want 0", busy); end
  endtask

  task automatic test_read;
    run_txn(1'b0, 2'b00, 20'h00123, 16'h0000);
    checks++; if (obs_oe_first != 1 || obs_oe_last != RD_WAIT || obs_oe_cnt != RD_WAIT) begin errors++; $display("FAIL read_oe_window got %0d..%0d n=%0d want 1..%0d", obs_oe_first, obs_oe_last, obs_oe_cnt, RD_WAIT); end
    checks++; if (obs_ce_cnt != RD_WAIT) begin errors++; $display("FAIL read_ce_cycles got %0d want %0d", obs_ce_cnt, RD_WAIT); end
    checks++; if (obs_ready_cyc != RD_WAIT + 1 || obs_ready_cnt != 1) begin errors++; $display("FAIL read_ready got cyc %0d n=%0d want cyc %0d n=1", obs_ready_cyc, obs_ready_cnt, RD_WAIT + 1); end
    checks++; if (obs_busy_cnt != RD_WAIT + 1) begin errors++; $display("FAIL read_busy got %0d want %0d", obs_busy_cnt, RD_WAIT + 1); end
    checks++; if (rdata !== 16'hBEEF) begin errors++; $display("FAIL read_rdata got %h want beef", rdata); end
    checks++; if (obs_a_bad != 0 || obs_we_cnt != 0 || obs_dqoe_cnt != 0 || obs_ublb_bad != 0) begin errors++; $display("FAIL read_pins a_bad=%0d we=%0d dqoe=%0d ublb=%0d want all 0", obs_a_bad, obs_we_cnt, obs_dqoe_cnt, obs_ublb_bad); end
  endtask

  task automatic test_write;
    logic [15:0] prev_rdata;
    prev_rdata = rdata;
    run_txn(1'b1, 2'b11, 20'h00040, 16'h1234);
    exp_mem[6'h00] = merge(exp_mem[6'h00], 16'h1234, 2'b11);
    checks++; if (obs_we_first != 2 || obs_we_cnt != WR_WAIT) begin errors++; $display("FAIL write_we_window got first %0d n=%0d want 2 n=%0d", obs_we_first, obs_we_cnt, WR_WAIT); end
    checks++; if (obs_dqoe_first != 1 || obs_dqoe_cnt != WR_WAIT + 2) begin errors++; $display("FAIL write_dqoe got first %0d n=%0d want 1 n=%0d", obs_dqoe_first, obs_dqoe_cnt, WR_WAIT + 2); end
    checks++; if (obs_ready_cyc != WR_WAIT + 3 || obs_ready_cnt != 1) begin errors++; $display("FAIL write_ready got cyc %0d n=%0d want cyc %0d n=1", obs_ready_cyc, obs_ready_cnt, WR_WAIT + 3); end
    checks++; if (obs_oe_cnt != 0 || obs_ublb_bad != 0 || obs_a_bad != 0) begin errors++; $display("FAIL write_pins oe=%0d ublb=%0d a_bad=%0d want 0", obs_oe_cnt, obs_ublb_bad, obs_a_bad); end
    checks++; if (sram[6'h00] !== 16'h1234) begin errors++; $display("FAIL write_mem got %h want 1234", sram[6'h00]); end
    checks++; if (dq_out !== 16'h1234 || rdata !== prev_rdata) begin errors++; $display("FAIL write_hold dq_out %h rdata %h want 1234 %h", dq_out, rdata, prev_rdata); end
  endtask

  task automatic test_byte_write;
    preload(6'h10, 16'hFFFF);
    run_txn(1'b1, 2'b01, 20'h00010, 16'hAB55);
    exp_mem[6'h10] = 16'hFF55;
    checks++; if (obs_ublb_bad != 0 || obs_we_cnt != WR_WAIT) begin errors++; $display("FAIL byte_strobes ublb_bad=%0d we=%0d want 0 %0d", obs_ublb_bad, obs_we_cnt, WR_WAIT); end
    checks++; if (sram[6'h10] !== 16'hFF55) begin errors++; $display("FAIL byte_mem got %h want ff55", sram[6'h10]); end
    run_txn(1'b1, 2'b00, 20'h00010, 16'h0000);
    checks++; if (sram[6'h10] !== 16'hFF55 || obs_ready_cnt != 1 || obs_we_cnt != WR_WAIT) begin errors++; $display("FAIL byte_none mem %h ready %0d we %0d want ff55 1 %0d", sram[6'h10], obs_ready_cnt, obs_we_cnt, WR_WAIT); end
  endtask

  task automatic test_random;
    logic        t_we;
    logic [1:0]  t_be;
    logic [19:0] t_addr;
    logic [15:0] t_wd, exp;
    for (int i = 0; i < 40; i++) begin
      t_we = 1'($urandom); t_be = 2'($urandom); t_addr = 20'($urandom); t_wd = 16'($urandom);
      if (t_we) exp = merge(exp_mem[t_addr[5:0]], t_wd, t_be);
      else      exp = exp_mem[t_addr[5:0]];
      run_txn(t_we, t_be, t_addr, t_wd);
      checks++; if (obs_ready_cyc != (t_we ? WR_WAIT + 3 : RD_WAIT + 1) || obs_ready_cnt != 1) begin errors++; $display("FAIL rnd_ready[%0d] we=%b got cyc %0d n=%0d", i, t_we, obs_ready_cyc, obs_ready_cnt); end
      checks++; if (obs_overlap != 0 || obs_a_bad != 0 || obs_ublb_bad != 0) begin errors++; $display("FAIL rnd_pins[%0d] overlap=%0d a_bad=%0d ublb=%0d want 0", i, obs_overlap, obs_a_bad, obs_ublb_bad); end
      if (t_we) begin
        exp_mem[t_addr[5:0]] = exp;
        checks++; if (sram[t_addr[5:0]] !== exp) begin errors++; $display("FAIL rnd_write[%0d] mem got %h want %h", i, sram[t_addr[5:0]], exp); end
      end else begin
        checks++; if (rdata !== exp) begin errors++; $display("FAIL rnd_read[%0d] rdata got %h want %h", i, rdata, exp); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d;
    int rdy1, rdy2, oe_first, ovl, idle_busy;
    d = 16'($urandom);
    rdy1 = 0; rdy2 = 0; oe_first = 0; ovl = 0; idle_busy = -1;
    req = 1'b1; we = 1'b1; be = 2'b11; addr = 20'h00A07; wdata = d;
    @(posedge Clk); #1;
    we = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge Clk);
      if (!OE_N && !WE_N) ovl++;
      if (c == WR_WAIT + 4) idle_busy = int'(busy);
      if (!OE_N && oe_first == 0) begin oe_first = c; req = 1'b0; end
      if (ready) begin
        if (rdy1 == 0) rdy1 = c;
        else if (rdy2 == 0) rdy2 = c;
      end
      if (rdy2 != 0) break;
    end
    @(posedge Clk); #1;
    req = 1'b0;
    exp_mem[6'h07] = d;
    checks++; if (rdy1 != WR_WAIT + 3) begin errors++; $display("FAIL b2b_write_ready got %0d want %0d", rdy1, WR_WAIT + 3); end
    checks++; if (idle_busy != 0 || oe_first != WR_WAIT + 5) begin errors++; $display("FAIL b2b_accept idle_busy=%0d oe_first=%0d want 0 %0d", idle_busy, oe_first, WR_WAIT + 5); end
    checks++; if (rdy2 != WR_WAIT + 5 + RD_WAIT) begin errors++; $display("FAIL b2b_read_ready got %0d want %0d", rdy2, WR_WAIT + 5 + RD_WAIT); end
    checks++; if (rdata !== d || ovl != 0) begin errors++; $display("FAIL b2b_data rdata %h overlap %0d want %h 0", rdata, ovl, d); end
  endtask

  task automatic test_reset_mid;
    int rdy;
    rdy = 0;
    req = 1'b1; we = 1'b1; be = 2'b11; addr = 20'h00033; wdata = exp_mem[6'h33];
    @(posedge Clk); #1;
    req = 1'b0;
    repeat (2) @(negedge Clk);
    checks++; if (WE_N !== 1'b0) begin errors++; $display("FAIL rst_mid_in_pulse WE_N got %b want 0", WE_N); end
    #2 Reset = 1'b1;
    #1;
    checks++; if ({CE_N, WE_N, dq_oe, busy} !== 4'b1100) begin errors++; $display("FAIL rst_mid_async CE_N,WE_N,dq_oe,busy got %b want 1100", {CE_N, WE_N, dq_oe, busy}); end
    repeat (2) begin @(negedge Clk); if (ready) rdy++; end
    Reset = 1'b0;
    repeat (4) begin @(negedge Clk); if (ready || busy) rdy++; end
    checks++; if (rdy != 0) begin errors++; $display("FAIL rst_mid_no_ready got %0d ready/busy cycles want 0", rdy); end
    @(posedge Clk); #1;
    run_txn(1'b0, 2'b00, 20'h00033, 16'h0);
    checks++; if (rdata !== exp_mem[6'h33] || obs_ready_cyc != RD_WAIT + 1) begin errors++; $display("FAIL rst_mid_recover rdata %h cyc %0d want %h %0d", rdata, obs_ready_cyc, exp_mem[6'h33], RD_WAIT + 1); end
  endtask

  task automatic test_ignored;
    int rdy, a_bad, bsy;
    rdy = 0; a_bad = 0; bsy = 0;
    req = 1'b1; we = 1'b0; addr = 20'h00123;
    @(posedge Clk); #1;
    req = 1'b0;
    for (int c = 1; c <= RD_WAIT + 6; c++) begin
      @(negedge Clk);
      if (A !== 20'h00123) a_bad++;
      if (ready) rdy++;
      if (busy) bsy++;
      if (c == 1) begin req = 1'b1; we = 1'b1; addr = 20'h5A5A5; end
      if (c == RD_WAIT) req = 1'b0;
    end
    @(posedge Clk); #1;
    checks++; if (a_bad != 0 || rdy != 1) begin errors++; $display("FAIL ignored_inputs a_bad=%0d readys=%0d want 0 1", a_bad, rdy); end
    checks++; if (bsy != RD_WAIT + 1 || rdata !== 16'hBEEF) begin errors++; $display("FAIL ignored_txn busy=%0d rdata=%h want %0d beef", bsy, rdata, RD_WAIT + 1); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) preload(6'(i), 16'($urandom));
    preload(6'h23, 16'hBEEF);
    test_reset;
    test_read;
    test_write;
    test_byte_write;
    test_back_to_back;
    test_reset_mid;
    test_ignored;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
